cmd_rx: RTL and testbench

// - Assembles SUMP command frames from the UART receiver byte stream.
// - Presents each complete frame to the instruction decoder as one strobed 40-bit word.
// - Sits between uart_rx and indec: drives indec stb_i/opc_i.
// - Short command: 1 byte, opcode bit7=0. Long command: 5 bytes, opcode bit7=1, then 4 data bytes, LSB first.
// - An inter-byte timeout discards stalled long frames so the host can always resynchronise.

---
 rtl/cmd_rx.sv | 129 ++++++++++++
 tb/tb_cmd_rx.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_rx.sv
// cmd_rx: assembles SUMP command frames from the UART byte stream.
// A short command is a single opcode byte with bit 7 clear. A long command is
// an opcode byte with bit 7 set followed by four data bytes, LSB first. Each
// complete frame is presented to the instruction decoder as one 40-bit word
// with a single-cycle strobe. An inter-byte timeout throws away a stalled long
// frame so the host can always resynchronise.
module cmd_rx #(
  parameter int unsigned TIMEOUT = 100000,
  parameter int unsigned CNT_W   = 17
) (
  input  logic        clk_i,
  input  logic        rst_in,
  input  logic [7:0]  rx_dat_i,
  input  logic        rx_stb_i,
  output logic        stb_o,
  output logic [39:0] cmd_o,
  output logic        busy_o,
  output logic        tout_o
);

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_e;

  // A zero TIMEOUT turns expiry off entirely; the counter then just saturates.
  localparam bit               TOUT_EN   = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TOUT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [1:0]         idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [39:0]        shadow_q, shadow_d;
  logic               stb_q, stb_d;
  logic [39:0]        cmd_q, cmd_d;
  logic               tout_q, tout_d;

  // Frame assembly: decides the next state, stores incoming data bytes in the
  // shadow word and raises the completion or timeout pulse for the next cycle.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    stb_d    = 1'b0;
    cmd_d    = cmd_q;
    tout_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (rx_stb_i) begin
          if (!rx_dat_i[7]) begin
            stb_d = 1'b1;
            cmd_d = {32'h0, rx_dat_i};
          end else begin
            shadow_d = {32'h0, rx_dat_i};
            idx_d    = 2'd0;
            cnt_d    = '0;
            state_d  = COLLECT;
          end
        end
      end

      COLLECT: begin
        if (rx_stb_i) begin
          // A byte arriving in the expiry cycle still wins over the timeout.
          cnt_d = '0;
          idx_d = idx_q + 2'd1;
          case (idx_q)
            2'd0:    shadow_d[15:8]  = rx_dat_i;
            2'd1:    shadow_d[23:16] = rx_dat_i;
            2'd2:    shadow_d[31:24] = rx_dat_i;
            default: shadow_d[39:32] = rx_dat_i;
          endcase
          if (idx_q == 2'd3) begin
            stb_d   = 1'b1;
            cmd_d   = {rx_dat_i, shadow_q[31:0]};
            idx_d   = 2'd0;
            state_d = IDLE;
          end
        end else begin
          if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          if (TOUT_EN && (cnt_q == TOUT_LAST)) begin
            tout_d   = 1'b1;
            idx_d    = 2'd0;
            cnt_d    = '0;
            shadow_d = '0;
            state_d  = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
        idx_d   = 2'd0;
        cnt_d   = '0;
      end
    endcase
  end

  // State and output registers; reset drops any partial frame silently.
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state_q  <= IDLE;
      idx_q    <= 2'd0;
      cnt_q    <= '0;
      shadow_q <= '0;
      stb_q    <= 1'b0;
      cmd_q    <= '0;
      tout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      stb_q    <= stb_d;
      cmd_q    <= cmd_d;
      tout_q   <= tout_d;
    end
  end

  assign stb_o  = stb_q;
  assign cmd_o  = cmd_q;
  assign tout_o = tout_q;
  assign busy_o = (state_q == COLLECT);

endmodule

// File: tb/tb_cmd_rx.sv
// Testbench for cmd_rx: directed SUMP frames plus randomized byte streams,
// checked through a scoreboard fed by a frame-level reference model.
module tb_cmd_rx;

  localparam int TOUT = 16;

  logic        clk;
  logic        rstN;
  logic [7:0]  rxDat;
  logic        rxStb;
  logic        stbO;
  logic [39:0] cmdO;
  logic        busyO;
  logic        toutO;

  typedef struct {
    bit          isStb;
    logic [39:0] cmd;
    int          due;
  } exp_t;

  exp_t        expQ[$];
  bit          busyExp[int];
  logic [7:0]  modelBytes[$];
  int          modelIdle;
  logic [39:0] cmdHeld;
  int          cyc;
  int          checks;
  int          errors;

  cmd_rx #(.TIMEOUT(TOUT), .CNT_W(5)) dut (
    .clk_i   (clk),
    .rst_in  (rstN),
    .rx_dat_i(rxDat),
    .rx_stb_i(rxStb),
    .stb_o   (stbO),
    .cmd_o   (cmdO),
    .busy_o  (busyO),
    .tout_o  (toutO)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter used to time-stamp expected events.
  always @(posedge clk) cyc <= cyc + 1;

  // Watchdog so the bench always terminates.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [39:0] actual, input logic [39:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h required %h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Frame-level reference: collects bytes into a list and emits events when a
  // frame is complete or when too many idle cycles pass inside a long frame.
  task automatic modelStep(input bit stb, input logic [7:0] dat);
    exp_t e;
    if (modelBytes.size() == 0) begin
      if (stb) begin
        if (dat < 8'h80) begin
          e.isStb = 1'b1; e.cmd = {32'h0, dat}; e.due = cyc + 1;
          expQ.push_back(e);
        end else begin
          modelBytes.push_back(dat);
          modelIdle = 0;
        end
      end
    end else begin
      if (stb) begin
        modelBytes.push_back(dat);
        modelIdle = 0;
        if (modelBytes.size() == 5) begin
          e.isStb = 1'b1;
          e.cmd   = {modelBytes[4], modelBytes[3], modelBytes[2], modelBytes[1], modelBytes[0]};
          e.due   = cyc + 1;
          expQ.push_back(e);
          modelBytes.delete();
        end
      end else begin
        modelIdle++;
        if (modelIdle == TOUT) begin
          e.isStb = 1'b0; e.cmd = '0; e.due = cyc + 1;
          expQ.push_back(e);
          modelBytes.delete();
        end
      end
    end
    busyExp[cyc + 1] = (modelBytes.size() != 0);
  endtask

  // Drive one cycle of input (idle when stb is 0) and advance the model.
  task automatic applyStimulus(input bit stb, input logic [7:0] dat);
    rxStb = stb;
    rxDat = stb ? dat : 8'($urandom);
    modelStep(stb, dat);
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00);
  endtask

  task automatic doReset(input int n);
    rstN  = 1'b0;
    rxStb = 1'b0;
    expQ.delete();
    busyExp.delete();
    modelBytes.delete();
    modelIdle = 0;
    cmdHeld   = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checkOutput("reset stb_o",  40'(stbO),  40'h0);
      checkOutput("reset cmd_o",  cmdO,       40'h0);
      checkOutput("reset busy_o", 40'(busyO), 40'h0);
      checkOutput("reset tout_o", 40'(toutO), 40'h0);
      @(posedge clk);
      #1;
    end
    rstN = 1'b1;
  endtask

  // Monitor: pops expected events whenever the DUT strobes and checks the
  // held command word and busy flag every cycle.
  always @(negedge clk) begin
    if (rstN) begin
      while (expQ.size() > 0 && expQ[0].due < cyc) begin
        checks++;
        errors++;
        $display("[TB] FAIL missed event: got none required %s due cycle %0d",
                 expQ[0].isStb ? "stb" : "tout", expQ[0].due);
        void'(expQ.pop_front());
      end
      if (stbO || toutO) begin
        if (expQ.size() == 0 || expQ[0].due != cyc) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected output: got stb=%0b tout=%0b required none (cycle %0d)",
                   stbO, toutO, cyc);
        end else begin
          exp_t e;
          e = expQ.pop_front();
          checkOutput("stb_o",  40'(stbO),  40'(e.isStb));
          checkOutput("tout_o", 40'(toutO), 40'(!e.isStb));
          if (e.isStb) cmdHeld = e.cmd;
        end
      end
      checkOutput("cmd_o", cmdO, cmdHeld);
      if (busyExp.exists(cyc)) checkOutput("busy_o", 40'(busyO), 40'(busyExp[cyc]));
    end
  end

  initial begin
    int gap;
    cyc = 0; checks = 0; errors = 0;
    rstN = 1'b0; rxStb = 1'b0; rxDat = 8'h00;
    modelIdle = 0; cmdHeld = '0;
    #1;
    doReset(3);

    // Short command.
    applyStimulus(1'b1, 8'h01);
    idleCycles(3);

    // Long command with irregular spacing below the timeout.
    applyStimulus(1'b1, 8'hC0); idleCycles(2);
    applyStimulus(1'b1, 8'h11); idleCycles(5);
    applyStimulus(1'b1, 8'h22);
    applyStimulus(1'b1, 8'h33); idleCycles(9);
    applyStimulus(1'b1, 8'h44);
    idleCycles(3);

    // Back-to-back frames, then a short opcode right after completion.
    applyStimulus(1'b1, 8'h02);
    applyStimulus(1'b1, 8'hC1);
    applyStimulus(1'b1, 8'hAA);
    applyStimulus(1'b1, 8'hBB);
    applyStimulus(1'b1, 8'hCC);
    applyStimulus(1'b1, 8'hDD);
    applyStimulus(1'b1, 8'h05);
    idleCycles(2);

    // Timeout discards the partial frame; next short command still works.
    applyStimulus(1'b1, 8'hC0);
    applyStimulus(1'b1, 8'h01);
    idleCycles(20);
    applyStimulus(1'b1, 8'h00);
    idleCycles(2);

    // Last data byte lands in the expiry cycle.
    applyStimulus(1'b1, 8'hC2);
    applyStimulus(1'b1, 8'h01);
    applyStimulus(1'b1, 8'h02);
    applyStimulus(1'b1, 8'h03);
    idleCycles(TOUT - 1);
    applyStimulus(1'b1, 8'h04);
    idleCycles(2);

    // Exactly TOUT idle cycles after the opcode expires the frame.
    applyStimulus(1'b1, 8'h9F);
    idleCycles(TOUT);
    applyStimulus(1'b1, 8'h7E);
    idleCycles(2);

    // Reset mid-frame.
    applyStimulus(1'b1, 8'hC0);
    applyStimulus(1'b1, 8'h01);
    applyStimulus(1'b1, 8'h02);
    doReset(3);
    applyStimulus(1'b1, 8'h11);
    idleCycles(2);

    // SUMP reset: five zero bytes.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'h00);
    idleCycles(2);

    // Randomized byte stream with mostly short gaps and occasional long ones.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) == 0) gap = $urandom_range(TOUT - 3, TOUT + 3);
      else                           gap = $urandom_range(0, 3);
      idleCycles(gap);
      applyStimulus(1'b1, 8'($urandom));
    end
    idleCycles(TOUT + 4);

    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending events required 0", expQ.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
